serial_pattern_tx: RTL and testbench

//  Serial bit-pattern transmitter. Drives a programmable pattern (e.g. 11101), MSB first,
//  one bit per clock onto a serial line; optional repeats with idle gap cycles.

---
 rtl/serial_pattern_tx.sv | 171 +++++++++++++++++
 tb/tb_serial_pattern_tx.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_pattern_tx.sv
// Serial bit-pattern transmitter: sends pattern[len-1..0] MSB first with optional repeats and gaps.
// Define SPT_PARITY_EN to append one even-parity bit after each repetition.
module serial_pattern_tx #(
   parameter int unsigned PAT_W = 8,
   parameter int unsigned LEN_W = 4,
   parameter int unsigned REP_W = 4,
   parameter int unsigned GAP_W = 4
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             start,
   input  logic             abort,
   input  logic [PAT_W-1:0] pattern,
   input  logic [LEN_W-1:0] pat_len,
   input  logic [REP_W-1:0] rep_cnt,
   input  logic [GAP_W-1:0] gap_len,
   output logic             dataout,
   output logic             valid,
   output logic             busy,
   output logic             done
);

`ifdef SPT_PARITY_EN
   typedef enum logic [2:0] {IDLE, SEND, GAP, DONE, PARITY} state_t;
`else
   typedef enum logic [2:0] {IDLE, SEND, GAP, DONE} state_t;
`endif

   state_t           state;
   logic [PAT_W-1:0] sh_pat;
   logic [LEN_W-1:0] sh_len;
   logic [REP_W-1:0] sh_rep;
   logic [GAP_W-1:0] sh_gap;
   logic [LEN_W-1:0] idx;
   logic [GAP_W-1:0] gcnt;

   logic [LEN_W-1:0] eff_len_c;
   logic             rep_end_c;
   logic             first_bit_c;
   logic             restart_bit_c;
   logic             next_bit_c;

   // Variable bit select without an over-wide index
   function automatic logic pat_bit(input logic [PAT_W-1:0] p, input logic [LEN_W-1:0] i);
      logic b;
      b = 1'b0;
      for (int k = 0; k < int'(PAT_W); k++)
         if (i == LEN_W'(k)) b = p[k];
      return b;
   endfunction

   assign eff_len_c     = (pat_len > LEN_W'(PAT_W)) ? LEN_W'(PAT_W) : pat_len;
   assign first_bit_c   = pat_bit(pattern, eff_len_c - LEN_W'(1));
   assign restart_bit_c = pat_bit(sh_pat, sh_len - LEN_W'(1));
   assign next_bit_c    = pat_bit(sh_pat, idx - LEN_W'(1));

`ifdef SPT_PARITY_EN
   logic sh_par;
   logic par_c;

   always_comb begin
      par_c = 1'b0;
      for (int k = 0; k < int'(PAT_W); k++)
         if (LEN_W'(k) < eff_len_c) par_c = par_c ^ pattern[k];
   end

   assign rep_end_c = (state == PARITY);
`else
   assign rep_end_c = (state == SEND) && (idx == '0);
`endif

   // Outputs are registered alongside the state they describe
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state   <= IDLE;
         sh_pat  <= '0;
         sh_len  <= '0;
         sh_rep  <= '0;
         sh_gap  <= '0;
         idx     <= '0;
         gcnt    <= '0;
`ifdef SPT_PARITY_EN
         sh_par  <= 1'b0;
`endif
         dataout <= 1'b0;
         valid   <= 1'b0;
         busy    <= 1'b0;
         done    <= 1'b0;
      end else if (abort && (state != IDLE)) begin
         state   <= IDLE;
         dataout <= 1'b0;
         valid   <= 1'b0;
         busy    <= 1'b0;
         done    <= 1'b0;
      end else if (rep_end_c) begin
         if (sh_rep != '0) begin
            sh_rep <= sh_rep - REP_W'(1);
            if (sh_gap != '0) begin
               state   <= GAP;
               gcnt    <= sh_gap - GAP_W'(1);
               dataout <= 1'b0;
               valid   <= 1'b0;
            end else begin
               state   <= SEND;
               idx     <= sh_len - LEN_W'(1);
               dataout <= restart_bit_c;
               valid   <= 1'b1;
            end
         end else begin
            state   <= DONE;
            dataout <= 1'b0;
            valid   <= 1'b0;
            done    <= 1'b1;
         end
      end else begin
         case (state)
            IDLE: begin
               if (start && (pat_len != '0)) begin
                  state   <= SEND;
                  sh_pat  <= pattern;
                  sh_len  <= eff_len_c;
                  sh_rep  <= rep_cnt;
                  sh_gap  <= gap_len;
`ifdef SPT_PARITY_EN
                  sh_par  <= par_c;
`endif
                  idx     <= eff_len_c - LEN_W'(1);
                  dataout <= first_bit_c;
                  valid   <= 1'b1;
                  busy    <= 1'b1;
               end
            end
            SEND: begin
`ifdef SPT_PARITY_EN
               if (idx == '0) begin
                  state   <= PARITY;
                  dataout <= sh_par;
               end else
`endif
               begin
                  idx     <= idx - LEN_W'(1);
                  dataout <= next_bit_c;
               end
            end
            GAP: begin
               if (gcnt == '0) begin
                  state   <= SEND;
                  idx     <= sh_len - LEN_W'(1);
                  dataout <= restart_bit_c;
                  valid   <= 1'b1;
               end else begin
                  gcnt <= gcnt - GAP_W'(1);
               end
            end
            DONE: begin
               state <= IDLE;
               done  <= 1'b0;
               busy  <= 1'b0;
            end
            default: begin
               state   <= IDLE;
               dataout <= 1'b0;
               valid   <= 1'b0;
               busy    <= 1'b0;
               done    <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_serial_pattern_tx.sv
// Bench for serial_pattern_tx: a per-cycle expectation queue built from the transmission rules,
// compared on every falling edge, plus literal checks of bit streams and done latency.
module tb_serial_pattern_tx;

   logic       clock = 1'b0;
   logic       reset;
   logic       start;
   logic       abort;
   logic [7:0] pattern;
   logic [3:0] pat_len;
   logic [3:0] rep_cnt;
   logic [3:0] gap_len;
   logic       dataout;
   logic       valid;
   logic       busy;
   logic       done;

   serial_pattern_tx #(.PAT_W(8), .LEN_W(4), .REP_W(4), .GAP_W(4)) dut (
      .clock(clock), .reset(reset), .start(start), .abort(abort),
      .pattern(pattern), .pat_len(pat_len), .rep_cnt(rep_cnt), .gap_len(gap_len),
      .dataout(dataout), .valid(valid), .busy(busy), .done(done)
   );

   always #5 clock = ~clock;

   typedef struct packed {
      logic d;
      logic v;
      logic b;
      logic dn;
   } exp_t;

   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   int   start_cyc = 0;
   int   done_cyc = -1;
   logic mon_en = 1'b0;
   exp_t q[$];
   exp_t last_exp = '0;
   logic seen[$];

`ifdef SPT_PARITY_EN
   localparam int PAR = 1;
`else
   localparam int PAR = 0;
`endif

   always @(posedge clock) cyc <= cyc + 1;

   // Per-cycle compare against the expectation queue (idle when empty)
   always @(negedge clock) begin
      if (mon_en) begin
         exp_t e;
         exp_t a;
         if (q.size() > 0) e = q.pop_front();
         else e = '0;
         a = '{dataout, valid, busy, done};
         checks++;
         if (a !== e) begin
            errors++;
            $display("FAIL cycle_out t=%0t got d/v/b/dn=%b%b%b%b required %b%b%b%b",
                     $time, a.d, a.v, a.b, a.dn, e.d, e.v, e.b, e.dn);
         end
         last_exp = e;
         if (valid === 1'b1) seen.push_back(dataout);
         if (done === 1'b1) done_cyc = cyc;
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input int got, input int req);
      checks++;
      if (got !== req) begin
         errors++;
         $display("FAIL %s got %0d required %0d", name, got, req);
      end
   endtask

   task automatic step();
      @(negedge clock);
      #1;
   endtask

   // Expected output stream of one accepted transmission
   task automatic build_txn(input logic [7:0] p, input int l, input int r, input int g);
      int len;
      int ones;
      len = (l > 8) ? 8 : l;
      for (int rep = 0; rep <= r; rep++) begin
         ones = 0;
         for (int i = len - 1; i >= 0; i--) begin
            q.push_back('{p[i], 1'b1, 1'b1, 1'b0});
            if (p[i]) ones++;
         end
         if (PAR != 0) q.push_back('{logic'(ones % 2), 1'b1, 1'b1, 1'b0});
         if (rep < r)
            for (int k = 0; k < g; k++) q.push_back('{1'b0, 1'b0, 1'b1, 1'b0});
      end
      q.push_back('{1'b0, 1'b0, 1'b1, 1'b1});
   endtask

   // Pulse start for one edge, then scramble inputs to show they were latched
   task automatic drive_start(input logic [7:0] p, input int l, input int r, input int g);
      pattern = p;
      pat_len = 4'(l);
      rep_cnt = 4'(r);
      gap_len = 4'(g);
      start   = 1'b1;
      if (q.size() == 0 && !last_exp.b && l != 0) begin
         build_txn(p, l, r, g);
         start_cyc = cyc;
         done_cyc  = -1;
         seen.delete();
      end
      @(posedge clock);
      #1;
      start   = 1'b0;
      pattern = ~p;
      pat_len = 4'(l + 3);
      rep_cnt = 4'(r + 5);
      gap_len = 4'(g + 2);
   endtask

   task automatic wait_idle();
      bit ok;
      ok = 1'b0;
      for (int k = 0; k < 300; k++) begin
         if (q.size() == 0 && !last_exp.b) begin
            ok = 1'b1;
            break;
         end
         step();
      end
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL wait_idle got busy required idle within 300 cycles");
      end
   endtask

   function automatic int seen_bits();
      int v;
      v = 0;
      foreach (seen[i]) v = (v << 1) | int'(seen[i]);
      return v;
   endfunction

   function automatic int detect_11101();
      int n;
      n = 0;
      for (int i = 0; i + 4 < seen.size(); i++)
         if (seen[i] && seen[i+1] && seen[i+2] && !seen[i+3] && seen[i+4]) n++;
      return n;
   endfunction

   initial begin
      reset = 1'b0;
      start = 1'b0;
      abort = 1'b0;
      pattern = '0;
      pat_len = '0;
      rep_cnt = '0;
      gap_len = '0;
      #12;
      chk("reset_outputs", int'({dataout, valid, busy, done}), 0);
      step();
      reset  = 1'b1;
      mon_en = 1'b1;
      step();

      // 11101 once
      drive_start(8'h1D, 5, 0, 0);
      wait_idle();
      chk("t1_done_latency", done_cyc - start_cyc, 6 + PAR);
      chk("t1_bits", seen_bits(), (PAR != 0) ? 32'b111010 : 32'b11101);

      // two back-to-back repetitions
      drive_start(8'h1D, 5, 1, 0);
      wait_idle();
      chk("t2_done_latency", done_cyc - start_cyc, 11 + 2 * PAR);
      chk("t2_bit_count", seen.size(), 10 + 2 * PAR);
      chk("t2_detections", detect_11101(), 2);

      // three repetitions with 3-cycle gaps
      drive_start(8'h1D, 5, 2, 3);
      wait_idle();
      chk("t3_done_latency", done_cyc - start_cyc, 22 + 3 * PAR);
      chk("t3_bit_count", seen.size(), 15 + 3 * PAR);

      // zero length ignored, over-long length clamped
      drive_start(8'hFF, 0, 0, 0);
      step();
      chk("t4_len0_busy", int'(busy), 0);
      step();
      drive_start(8'hA5, 12, 0, 0);
      wait_idle();
      chk("t4_clamp_bits", seen_bits(), (PAR != 0) ? 32'b101001010 : 32'hA5);
      chk("t4_clamp_latency", done_cyc - start_cyc, 9 + PAR);

      // abort during the third bit
      drive_start(8'h1D, 5, 0, 0);
      step();
      step();
      step();
      abort = 1'b1;
      q.delete();
      @(posedge clock);
      #1;
      abort = 1'b0;
      step();
      chk("t5_abort_busy", int'(busy), 0);
      step();
      chk("t5_abort_bits_sent", seen.size(), 3);
      chk("t5_abort_no_done", done_cyc, -1);

      // abort while idle has no effect
      abort = 1'b1;
      step();
      abort = 1'b0;
      step();

      // start while busy ignored
      drive_start(8'h1D, 5, 1, 0);
      step();
      step();
      drive_start(8'hFF, 8, 0, 0);
      wait_idle();
      chk("t5_busy_start_bits", seen.size(), 10 + 2 * PAR);
      chk("t5_busy_start_latency", done_cyc - start_cyc, 11 + 2 * PAR);

      // start during the DONE cycle ignored
      drive_start(8'h03, 2, 0, 0);
      for (int k = 0; k < 20 && !last_exp.dn; k++) step();
      drive_start(8'h03, 2, 0, 0);
      wait_idle();
      step();
      step();
      chk("t5_done_start_busy", int'(busy), 0);

      // async reset mid-transmission
      drive_start(8'h1D, 5, 0, 0);
      step();
      step();
      reset = 1'b0;
      #1;
      chk("t5_reset_outputs", int'({dataout, valid, busy, done}), 0);
      q.delete();
      last_exp = '0;
      step();
      reset = 1'b1;
      step();
      step();
      chk("t5_reset_no_done", done_cyc, -1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
